// File: rtl/prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Multi-channel interrupt coalescer: drains per-channel event FIFOs and emits one
// ISR pulse per closed batch (count threshold, timeout, enable drop or flush).
module prism_sp_puzzle_hw_gem_irq_coalesce #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 8,
  parameter int TIMER_WIDTH  = 16
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [NUM_CHANNELS-1:0]             fifo_empty,
  output logic [NUM_CHANNELS-1:0]             fifo_rd_en,
  input  logic [NUM_CHANNELS-1:0]             chan_enable,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] coal_thresh,
  input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] coal_timeout,
  input  logic                                flush,
  output logic [NUM_CHANNELS-1:0]             isr_pulses,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] batch_count
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  assign fifo_rd_en = {NUM_CHANNELS{resetn}} & chan_enable & ~fifo_empty;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    state_t                 r_state;
    state_t                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_pending;
    logic [COUNT_WIDTH-1:0] w_pending_next;
    logic [COUNT_WIDTH-1:0] w_pending_store;
    logic [COUNT_WIDTH-1:0] r_batch;
    logic [COUNT_WIDTH-1:0] w_batch_next;
    logic [COUNT_WIDTH-1:0] w_thresh;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [TIMER_WIDTH-1:0] w_timer_next;
    logic [TIMER_WIDTH-1:0] w_timer_store;
    logic [TIMER_WIDTH-1:0] w_timeout;
    logic                   r_en_d;
    logic                   r_isr;
    logic                   w_pop;
    logic                   w_en_fall;
    logic                   w_close;

    assign w_thresh  = coal_thresh[gi*COUNT_WIDTH +: COUNT_WIDTH];
    assign w_timeout = coal_timeout[gi*TIMER_WIDTH +: TIMER_WIDTH];
    assign w_pop     = fifo_rd_en[gi];
    assign w_en_fall = r_en_d & ~chan_enable[gi];

    always_comb begin
      w_pending_next  = r_pending;
      w_timer_next    = r_timer;
      w_close         = 1'b0;
      w_state_next    = r_state;
      w_pending_store = r_pending;
      w_timer_store   = r_timer;
      w_batch_next    = r_batch;

      case (r_state)
        S_IDLE: begin
          w_pending_next = w_pop ? COUNT_WIDTH'(1) : '0;
          w_timer_next   = w_pop ? TIMER_WIDTH'(1) : '0;
        end
        S_ACCUM: begin
          w_pending_next = r_pending + COUNT_WIDTH'(w_pop);
          w_timer_next   = (&r_timer) ? r_timer : r_timer + TIMER_WIDTH'(1);
        end
        default: ;
      endcase

      // A zero threshold behaves as 1: any non-empty batch already satisfies >= 0.
      if (w_pending_next != '0) begin
        w_close = (w_pending_next >= w_thresh)
                | ((w_timeout != '0) & (w_timer_next >= w_timeout))
                | flush
                | w_en_fall;
      end

      if (w_close) begin
        w_state_next    = S_IDLE;
        w_pending_store = '0;
        w_timer_store   = '0;
        w_batch_next    = w_pending_next;
      end else begin
        w_state_next    = (w_pending_next != '0) ? S_ACCUM : S_IDLE;
        w_pending_store = w_pending_next;
        w_timer_store   = w_timer_next;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_state   <= S_IDLE;
        r_pending <= '0;
        r_timer   <= '0;
        r_batch   <= '0;
        r_isr     <= 1'b0;
        r_en_d    <= 1'b0;
      end else begin
        r_state   <= w_state_next;
        r_pending <= w_pending_store;
        r_timer   <= w_timer_store;
        r_batch   <= w_batch_next;
        r_isr     <= w_close;
        r_en_d    <= chan_enable[gi];
      end
    end

    assign isr_pulses[gi]                             = r_isr;
    assign batch_count[gi*COUNT_WIDTH +: COUNT_WIDTH] = r_batch;
  end

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Directed plus randomized bench for the interrupt coalescer, checked against an
// event-count / batch-age reference model.
module tb_prism_sp_puzzle_hw_gem_irq_coalesce;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int TW = 16;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_rd_en;
  logic [N-1:0]    chan_enable;
  logic [N*CW-1:0] coal_thresh;
  logic [N*TW-1:0] coal_timeout;
  logic            flush;
  logic [N-1:0]    isr_pulses;
  logic [N*CW-1:0] batch_count;

  int fifo_cnt [N];
  int th       [N];
  int to       [N];

  // Reference model: open batch size and the cycle its first event was popped.
  int m_pend   [N];
  int m_start  [N];
  bit m_prev_en[N];
  logic [N-1:0]    exp_isr;
  logic [N-1:0]    exp_pop;
  logic [N*CW-1:0] exp_batch;
  int cycle;
  int tests_run;
  int fails;

  prism_sp_puzzle_hw_gem_irq_coalesce #(
    .NUM_CHANNELS(N), .COUNT_WIDTH(CW), .TIMER_WIDTH(TW)
  ) dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .chan_enable(chan_enable), .coal_thresh(coal_thresh), .coal_timeout(coal_timeout),
    .flush(flush), .isr_pulses(isr_pulses), .batch_count(batch_count)
  );

  always #5 clock = ~clock;

  always_comb begin
    fifo_empty   = '0;
    coal_thresh  = '0;
    coal_timeout = '0;
    for (int c = 0; c < N; c++) begin
      fifo_empty[c]             = (fifo_cnt[c] == 0);
      coal_thresh[c*CW +: CW]   = CW'(th[c]);
      coal_timeout[c*TW +: TW]  = TW'(to[c]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_eval();
    int cnt;
    int tn;
    int thr;
    bit pop;
    bit close;
    if (!resetn) begin
      for (int c = 0; c < N; c++) begin
        m_pend[c]    = 0;
        m_prev_en[c] = 1'b0;
      end
      exp_isr   = '0;
      exp_pop   = '0;
      exp_batch = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        pop        = chan_enable[c] && (fifo_cnt[c] > 0);
        exp_pop[c] = pop;
        cnt        = m_pend[c] + (pop ? 1 : 0);
        if (m_pend[c] == 0 && pop) m_start[c] = cycle;
        tn    = (cnt == 0) ? 0 : cycle - m_start[c] + 1;
        if (tn > 65535) tn = 65535;
        thr   = (th[c] == 0) ? 1 : th[c];
        close = (cnt > 0) && ((cnt >= thr) || (to[c] != 0 && tn >= to[c]) || flush
                              || (m_prev_en[c] && !chan_enable[c]));
        exp_isr[c] = close;
        if (close) begin
          exp_batch[c*CW +: CW] = CW'(cnt);
          m_pend[c]             = 0;
        end else begin
          m_pend[c] = cnt;
        end
        m_prev_en[c] = chan_enable[c];
      end
    end
    cycle++;
  endtask

  // One clock: check the combinational pop, clock, then check the registered outputs.
  task automatic tick();
    #1;
    model_eval();
    check("rd_en", 64'(fifo_rd_en), 64'(exp_pop));
    @(posedge clock);
    @(negedge clock);
    for (int c = 0; c < N; c++) if (exp_pop[c]) fifo_cnt[c]--;
    check("isr", 64'(isr_pulses), 64'(exp_isr));
    check("batch", 64'(batch_count), 64'(exp_batch));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hit;
    tests_run = 0;
    fails     = 0;
    cycle     = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    chan_enable = '1;
    for (int c = 0; c < N; c++) begin
      fifo_cnt[c] = 0; th[c] = 1; to[c] = 0; m_pend[c] = 0; m_start[c] = 0; m_prev_en[c] = 0;
    end
    fifo_cnt[0] = 2;
    exp_isr = '0; exp_pop = '0; exp_batch = '0;
    ticks(3);
    check("reset_rd_en", 64'(fifo_rd_en), 64'h0);
    fifo_cnt[0] = 0;
    resetn = 1'b1;
    ticks(2);

    // Threshold 1: one pulse per event.
    fifo_cnt[0] = 3;
    ticks(6);

    // Threshold 4 on 10 events, flush the leftover 2.
    th[1] = 4;
    fifo_cnt[1] = 10;
    ticks(12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(2);

    // Timeout 20 on a single event: pulse exactly 20 cycles after the pop.
    th[2] = 8; to[2] = 20;
    fifo_cnt[2] = 1;
    hit = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (isr_pulses[2] && hit == 0) hit = i;
    end
    check("timeout_lat", 64'(hit), 64'd20);
    to[2] = 0;

    // Threshold lowered below the pending count mid-batch.
    th[3] = 5;
    fifo_cnt[3] = 3;
    ticks(4);
    th[3] = 2;
    ticks(3);

    // Enable drop with 2 pending, then more data that must stay unpopped.
    th[0] = 8;
    fifo_cnt[0] = 2;
    ticks(3);
    chan_enable[0] = 1'b0;
    fifo_cnt[0] = 3;
    ticks(4);
    chan_enable[0] = 1'b1;
    ticks(5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Reset mid-batch discards pending events.
    for (int c = 0; c < N; c++) begin th[c] = 10; fifo_cnt[c] = 3; end
    ticks(4);
    resetn = 1'b0;
    #1;
    check("async_rst_isr", 64'(isr_pulses), 64'h0);
    check("async_rst_batch", 64'(batch_count), 64'h0);
    ticks(2);
    resetn = 1'b1;
    ticks(3);
    for (int c = 0; c < N; c++) begin th[c] = 1; fifo_cnt[c] = 1; end
    tick();
    check("all_pulse", 64'(isr_pulses), 64'hF);
    ticks(2);

    // Randomized traffic, enables, thresholds, timeouts and flushes.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (fifo_cnt[c] == 0 && $urandom_range(0, 3) == 0) fifo_cnt[c] = $urandom_range(1, 6);
        if ($urandom_range(0, 15) == 0) chan_enable[c] = ~chan_enable[c];
        if ($urandom_range(0, 19) == 0) th[c] = $urandom_range(0, 6);
        if ($urandom_range(0, 19) == 0) to[c] = $urandom_range(0, 15);
      end
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    flush = 1'b0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/prism_sp_puzzle_hw_gem_irq_coalesce.md
# prism_sp_puzzle_hw_gem_irq_coalesce

Multi-channel interrupt coalescer for the GEM puzzle pieces. It drains NUM_CHANNELS event FIFOs (one word per completed GEM event) and raises one single-cycle ISR pulse per channel per batch of events. A batch closes on a per-channel count threshold, a per-channel timeout, a disable, or a global flush. It sits between the GEM event FIFOs and the MMR interrupt block (isr_pulses); the count of the closed batch is exported for the MMR status registers. With threshold 1 and timeout 0 on every channel, it gives one pulse per event, one cycle after the pop.

## Interface
- NUM_CHANNELS, 4: number of independent event channels (1..32).
- COUNT_WIDTH, 8: width of event counter and threshold.
- TIMER_WIDTH, 16: width of timeout counter and timeout value.

- clock  input  1  single clock; all state on posedge.
- resetn  input  1  asynchronous, active-low reset.
- fifo_empty  input  NUM_CHANNELS  per-channel FIFO empty (show-ahead FIFO).
- fifo_rd_en  output  NUM_CHANNELS  per-channel pop strobe, combinational.
- chan_enable  input  NUM_CHANNELS  per-channel enable.
- coal_thresh  input  NUM_CHANNELS*COUNT_WIDTH  packed event-count threshold per channel; 0 treated as 1.
- coal_timeout  input  NUM_CHANNELS*TIMER_WIDTH  packed timeout in cycles per channel; 0 disables the timeout.
- flush  input  1  closes every open batch (single-cycle strobe or level).
- isr_pulses  output  NUM_CHANNELS  registered one-cycle interrupt pulse per channel.
- batch_count  output  NUM_CHANNELS*COUNT_WIDTH  registered event count of the last closed batch per channel.

## Operation
- Channel c behaves as follows; channels are fully independent except for the shared flush.
- Pop: fifo_rd_en[c] = resetn & chan_enable[c] & !fifo_empty[c]. Each popped word adds 1 event. There is one pop per cycle at most, and pops run at full throughput.
- State per channel: IDLE (pending=0, timer=0) and ACCUM (pending≥1).
- IDLE→ACCUM happens on a pop. pending becomes 1 and timer becomes 1.
- In ACCUM: pending increments on each pop. timer increments every cycle, saturating at all-ones.
- Close condition, evaluated on next-state values:
  - pending_next ≥ max(thresh,1), or
  - (timeout≠0 and timer_next ≥ timeout), or
  - (flush and pending_next≥1), or
  - (falling edge of chan_enable with pending≥1).
- On close:
  - isr_pulses[c] goes high for exactly one cycle.
  - batch_count[c] takes pending_next.
  - The channel returns to IDLE.
- The count cannot overflow: pending never exceeds thresh ≤ 2^COUNT_WIDTH−1.
- Disabled channel: no pops. An open batch is flushed once on the falling edge of enable, then the channel stays IDLE.
- Threshold or timeout change mid-batch: the comparisons use live values. A threshold lowered to ≤ pending closes the batch in the next cycle.
- A flush with no pending events produces no pulse.

## Timing
- Reset values: isr_pulses=0, batch_count=0, all channels IDLE. fifo_rd_en=0 while resetn is low.
- Reset asserted mid-batch discards pending events without a pulse.
- Threshold latency: the pop that reaches the threshold in cycle t gives isr_pulses high in cycle t+1.
- Timeout latency: first pop in cycle t with no threshold hit gives the pulse in cycle t+timeout.
- A flush sampled in cycle t gives the pulse in cycle t+1. A pop in that same cycle t is included in the flushed batch.
- Back-to-back batches:
  - A pop in the cycle in which isr_pulses is high starts a new batch (pending=1).
  - Consecutive pulses are possible with thresh=1 (pulse every cycle under continuous pops).
- Simultaneous causes in one cycle (threshold, timeout, flush) produce a single pulse.

## Test plan
- Threshold 1, timeout 0, chan0 FIFO holds 3 words, empty otherwise: fifo_rd_en[0] high 3 cycles → isr_pulses[0] high on 3 consecutive cycles, each batch_count=1.
- Threshold 4, timeout 0, 10 events on chan1 at full rate → pulses 4 and 8 cycles after the first pop cycle (batch_count=4 each). The remaining 2 events stay pending with no pulse until flush → pulse next cycle with batch_count=2.
- Threshold 8, timeout 20, single event on chan2 at cycle t → pulse exactly at t+20 with batch_count=1; no further pulse.
- Threshold 5, 3 events pending on chan3, coal_thresh lowered to 2 → pulse next cycle with batch_count=3.
- Chan0 with 2 pending events, chan_enable[0] dropped → one pulse (batch_count=2); fifo_rd_en[0] stays low while more FIFO data is present.
- Reset asserted with 3 events pending on every channel → outputs 0 immediately, no pulse after release. Then threshold 1 and 4 channels popping simultaneously → all isr_pulses bits high in the same cycle.
